// File: rtl/ex_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ex_stage_pkg : widths, alusel/aluop encodings and divider FSM states        |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
package ex_stage_pkg;

  localparam int DATA_SIZE                = 32;
  localparam int INSTRUCTION_ADDRESS_SIZE = 32;
  localparam int DATA_ADDRESS_SIZE        = 32;
  localparam int ALUSEL_SIZE              = 4;
  localparam int ALUOP_SIZE               = 4;

  localparam logic [ALUSEL_SIZE-1:0] ALUSEL_NOP     = 4'd0;
  localparam logic [ALUSEL_SIZE-1:0] ALUSEL_LOGIC   = 4'd1;
  localparam logic [ALUSEL_SIZE-1:0] ALUSEL_ARITH   = 4'd2;
  localparam logic [ALUSEL_SIZE-1:0] ALUSEL_SHIFT   = 4'd3;
  localparam logic [ALUSEL_SIZE-1:0] ALUSEL_COMPARE = 4'd4;
  localparam logic [ALUSEL_SIZE-1:0] ALUSEL_BRANCH  = 4'd5;
  localparam logic [ALUSEL_SIZE-1:0] ALUSEL_JUMP    = 4'd6;
  localparam logic [ALUSEL_SIZE-1:0] ALUSEL_LOAD    = 4'd7;
  localparam logic [ALUSEL_SIZE-1:0] ALUSEL_STORE   = 4'd8;
  localparam logic [ALUSEL_SIZE-1:0] ALUSEL_MULDIV  = 4'd9;

  localparam logic [ALUOP_SIZE-1:0] OP_AND    = 4'd0;
  localparam logic [ALUOP_SIZE-1:0] OP_OR     = 4'd1;
  localparam logic [ALUOP_SIZE-1:0] OP_XOR    = 4'd2;
  localparam logic [ALUOP_SIZE-1:0] OP_ADD    = 4'd0;
  localparam logic [ALUOP_SIZE-1:0] OP_SUB    = 4'd1;
  localparam logic [ALUOP_SIZE-1:0] OP_SLL    = 4'd0;
  localparam logic [ALUOP_SIZE-1:0] OP_SRL    = 4'd1;
  localparam logic [ALUOP_SIZE-1:0] OP_SRA    = 4'd2;
  localparam logic [ALUOP_SIZE-1:0] OP_SLT    = 4'd0;
  localparam logic [ALUOP_SIZE-1:0] OP_SLTU   = 4'd1;
  localparam logic [ALUOP_SIZE-1:0] OP_BEQ    = 4'd0;
  localparam logic [ALUOP_SIZE-1:0] OP_BNE    = 4'd1;
  localparam logic [ALUOP_SIZE-1:0] OP_BLT    = 4'd2;
  localparam logic [ALUOP_SIZE-1:0] OP_BGE    = 4'd3;
  localparam logic [ALUOP_SIZE-1:0] OP_BLTU   = 4'd4;
  localparam logic [ALUOP_SIZE-1:0] OP_BGEU   = 4'd5;
  localparam logic [ALUOP_SIZE-1:0] OP_JAL    = 4'd0;
  localparam logic [ALUOP_SIZE-1:0] OP_JALR   = 4'd1;
  localparam logic [ALUOP_SIZE-1:0] OP_MUL    = 4'd0;
  localparam logic [ALUOP_SIZE-1:0] OP_MULH   = 4'd1;
  localparam logic [ALUOP_SIZE-1:0] OP_MULHSU = 4'd2;
  localparam logic [ALUOP_SIZE-1:0] OP_MULHU  = 4'd3;
  localparam logic [ALUOP_SIZE-1:0] OP_DIV    = 4'd4;
  localparam logic [ALUOP_SIZE-1:0] OP_DIVU   = 4'd5;
  localparam logic [ALUOP_SIZE-1:0] OP_REM    = 4'd6;
  localparam logic [ALUOP_SIZE-1:0] OP_REMU   = 4'd7;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input logic [ALUSEL_SIZE-1:0] sel,
                                     input logic [ALUOP_SIZE-1:0]  op);
    return (sel == ALUSEL_MULDIV) &&
           ((op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ex_stage_if : ID/EX operands in, execute results and control out            |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [INSTRUCTION_ADDRESS_SIZE-1:0] pc;
  logic [ALUSEL_SIZE-1:0]              alusel;
  logic [ALUOP_SIZE-1:0]               aluop;
  logic [DATA_SIZE-1:0]                op1;
  logic [DATA_SIZE-1:0]                op2;
  logic                                write_flag;
  logic [DATA_ADDRESS_SIZE-1:0]        sl_address;
  logic [DATA_ADDRESS_SIZE-1:0]        sl_offset;
  logic [INSTRUCTION_ADDRESS_SIZE-1:0] br_address;
  logic [INSTRUCTION_ADDRESS_SIZE-1:0] br_offset;
  logic                                prediction;

  logic [DATA_SIZE-1:0]                ex_result;
  logic                                ex_write_flag;
  logic [DATA_ADDRESS_SIZE-1:0]        ex_mem_address;
  logic [ALUSEL_SIZE-1:0]              ex_alusel;
  logic [ALUOP_SIZE-1:0]               ex_aluop;
  logic [DATA_SIZE-1:0]                ex_store_data;
  logic                                discard;
  logic [INSTRUCTION_ADDRESS_SIZE-1:0] redirect_pc;
  logic                                stall_req;
  logic                                bp_update;
  logic [INSTRUCTION_ADDRESS_SIZE-1:0] bp_pc;
  logic                                bp_taken;

  modport master (
    output pc, alusel, aluop, op1, op2, write_flag, sl_address, sl_offset,
           br_address, br_offset, prediction,
    input  ex_result, ex_write_flag, ex_mem_address, ex_alusel, ex_aluop,
           ex_store_data, discard, redirect_pc, stall_req, bp_update, bp_pc, bp_taken
  );

  modport slave (
    input  pc, alusel, aluop, op1, op2, write_flag, sl_address, sl_offset,
           br_address, br_offset, prediction,
    output ex_result, ex_write_flag, ex_mem_address, ex_alusel, ex_aluop,
           ex_store_data, discard, redirect_pc, stall_req, bp_update, bp_pc, bp_taken
  );
endinterface
`default_nettype wire

// File: rtl/ex_stage_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_unit : serial restoring divider, one quotient bit per cycle, sign fix-up |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module div_unit
  import ex_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_STEPS = 32
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            start,
  input  wire logic            is_signed,
  input  wire logic            is_rem,
  input  wire logic [XLEN-1:0] dividend,
  input  wire logic [XLEN-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [XLEN-1:0]      result
);

  localparam int              CW      = $clog2(DIV_STEPS + 1);
  localparam logic [CW-1:0]   C_STEPS = CW'(DIV_STEPS);

  div_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [XLEN-1:0]  rem_q, quo_q, dvs_q;
  logic             quo_neg_q, rem_neg_q, is_rem_q;

  logic             dvd_neg, dvs_neg;
  logic [XLEN-1:0]  dvd_mag, dvs_mag;
  logic [XLEN:0]    shifted_d, diff_d;
  logic [XLEN-1:0]  rem_d, quo_d, mag;
  logic             neg;

  always_comb begin
    dvd_neg   = is_signed & dividend[XLEN-1];
    dvs_neg   = is_signed & divisor[XLEN-1];
    dvd_mag   = dvd_neg ? -dividend : dividend;
    dvs_mag   = dvs_neg ? -divisor  : divisor;
    // quo_q starts as the dividend and shifts its MSB into the partial remainder
    shifted_d = {rem_q, quo_q[XLEN-1]};
    diff_d    = shifted_d - {1'b0, dvs_q};
    if (diff_d[XLEN]) begin
      rem_d = shifted_d[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_d = diff_d[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b1};
    end
    mag    = is_rem_q ? rem_q     : quo_q;
    neg    = is_rem_q ? rem_neg_q : quo_neg_q;
    result = neg ? -mag : mag;
    busy   = (state_q == DIV_BUSY);
    done   = (state_q == DIV_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            rem_q     <= '0;
            quo_q     <= dvd_mag;
            dvs_q     <= dvs_mag;
            quo_neg_q <= dvd_neg ^ dvs_neg;
            rem_neg_q <= dvd_neg;
            is_rem_q  <= is_rem;
            cnt_q     <= C_STEPS;
            state_q   <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= DIV_DONE;
        end
        DIV_DONE: state_q <= DIV_IDLE;
        default:  state_q <= DIV_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ex_stage : RV32IM execute - ALU, multiplier, branch resolution, divider     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_STEPS = 32
) (
  input  wire logic   clk,
  input  wire logic   rst,
  ex_stage_if.slave   io
);

  localparam int IAW = INSTRUCTION_ADDRESS_SIZE;

  logic              slt, ult, cond, taken, is_ctrl, is_jalr;
  logic              a_sgn, b_sgn;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic [4:0]        shamt;
  logic [IAW-1:0]    pc_plus4, target, target_fix, redirect;
  logic [XLEN-1:0]   alu_result, div_result, special_res;
  logic              is_div, div_signed, div_rem, div_zero, div_ovf, div_special;
  logic              div_start, div_busy, div_done, stall_raw;

  always_comb begin
    shamt       = io.op2[4:0];
    slt         = $signed(io.op1) < $signed(io.op2);
    ult         = io.op1 < io.op2;
    a_sgn       = (io.aluop == OP_MULH) || (io.aluop == OP_MULHSU);
    b_sgn       = (io.aluop == OP_MULH);
    a_ext       = {{XLEN{a_sgn & io.op1[XLEN-1]}}, io.op1};
    b_ext       = {{XLEN{b_sgn & io.op2[XLEN-1]}}, io.op2};
    prod        = a_ext * b_ext;
    pc_plus4    = io.pc + IAW'(4);
    is_jalr     = (io.alusel == ALUSEL_JUMP) && (io.aluop == OP_JALR);
    target      = io.br_address + io.br_offset;
    target_fix  = {target[IAW-1:1], target[0] & ~is_jalr};

    is_div      = is_div_op(io.alusel, io.aluop);
    div_signed  = (io.aluop == OP_DIV) || (io.aluop == OP_REM);
    div_rem     = (io.aluop == OP_REM) || (io.aluop == OP_REMU);
    div_zero    = (io.op2 == '0);
    div_ovf     = div_signed && (io.op1 == {1'b1, {(XLEN-1){1'b0}}}) && (io.op2 == '1);
    div_special = div_zero | div_ovf;
    // Divide-by-zero yields all ones / op1; overflow yields op1 (0x80000000) / 0
    if (div_zero) special_res = div_rem ? io.op1 : '1;
    else          special_res = div_rem ? '0     : io.op1;
    div_start   = is_div & ~div_special;
  end

  div_unit #(.XLEN(XLEN), .DIV_STEPS(DIV_STEPS)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .is_signed (div_signed),
    .is_rem    (div_rem),
    .dividend  (io.op1),
    .divisor   (io.op2),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_result)
  );

  // Launch cycle stalls too, so the operands stay put until the first BUSY edge
  assign stall_raw = (div_start & ~div_busy & ~div_done) | div_busy;

  always_comb begin
    alu_result = '0;
    cond       = 1'b0;
    taken      = 1'b0;
    is_ctrl    = 1'b0;
    case (io.alusel)
      ALUSEL_LOGIC: begin
        case (io.aluop)
          OP_AND:  alu_result = io.op1 & io.op2;
          OP_OR:   alu_result = io.op1 | io.op2;
          OP_XOR:  alu_result = io.op1 ^ io.op2;
          default: alu_result = '0;
        endcase
      end
      ALUSEL_ARITH: alu_result = (io.aluop == OP_SUB) ? io.op1 - io.op2 : io.op1 + io.op2;
      ALUSEL_SHIFT: begin
        case (io.aluop)
          OP_SLL:  alu_result = io.op1 << shamt;
          OP_SRL:  alu_result = io.op1 >> shamt;
          OP_SRA:  alu_result = $signed(io.op1) >>> shamt;
          default: alu_result = '0;
        endcase
      end
      ALUSEL_COMPARE: alu_result = {{(XLEN-1){1'b0}}, (io.aluop == OP_SLTU) ? ult : slt};
      ALUSEL_BRANCH: begin
        is_ctrl = 1'b1;
        case (io.aluop)
          OP_BEQ:  cond = (io.op1 == io.op2);
          OP_BNE:  cond = (io.op1 != io.op2);
          OP_BLT:  cond = slt;
          OP_BGE:  cond = ~slt;
          OP_BLTU: cond = ult;
          OP_BGEU: cond = ~ult;
          default: cond = 1'b0;
        endcase
        taken = cond;
      end
      ALUSEL_JUMP: begin
        is_ctrl    = 1'b1;
        taken      = 1'b1;
        alu_result = pc_plus4;
      end
      ALUSEL_MULDIV: begin
        case (io.aluop)
          OP_MUL:                        alu_result = prod[XLEN-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU:  alu_result = prod[2*XLEN-1:XLEN];
          OP_DIV, OP_DIVU, OP_REM, OP_REMU:
            alu_result = div_done ? div_result : (div_special ? special_res : '0);
          default:                       alu_result = '0;
        endcase
      end
      default: alu_result = '0;
    endcase
    redirect = taken ? target_fix : pc_plus4;
  end

  assign io.ex_result      = rst ? '0 : alu_result;
  assign io.ex_write_flag  = ~rst & io.write_flag & ~stall_raw;
  assign io.ex_mem_address = rst ? '0 : io.sl_address + io.sl_offset;
  assign io.ex_alusel      = rst ? '0 : io.alusel;
  assign io.ex_aluop       = rst ? '0 : io.aluop;
  assign io.ex_store_data  = rst ? '0 : io.op2;
  assign io.discard        = ~rst & is_ctrl & (taken != io.prediction) & ~stall_raw;
  assign io.redirect_pc    = rst ? '0 : redirect;
  assign io.stall_req      = ~rst & stall_raw;
  assign io.bp_update      = ~rst & is_ctrl & ~stall_raw;
  assign io.bp_pc          = rst ? '0 : io.pc;
  assign io.bp_taken       = ~rst & taken;

endmodule
`default_nettype wire
